// File: rtl/dsp_pkg.sv
// dsp_pkg: shared widths, multiplier sideband and saturation helpers
// for the streaming MAC lane.
package dsp_pkg;

    localparam int DSP_A_W   = 27;
    localparam int DSP_B_W   = 18;
    localparam int DSP_ACC_W = 48;

    // Per-beat control that travels with the product.
    // The bias travels beside it because its width follows ACC_WIDTH.
    typedef struct packed {
        logic first;
        logic last;
        logic sub;
    } sb_t;

    // Two non-negative operands producing a negative sum: clamp to max.
    function automatic logic sat_hi(logic sa, logic sb, logic ss);
        return !sa && !sb && ss;
    endfunction

    // Two negative operands producing a non-negative sum: clamp to min.
    function automatic logic sat_lo(logic sa, logic sb, logic ss);
        return sa && sb && !ss;
    endfunction

endpackage

// File: rtl/dsp_mul_pipe.sv
// dsp_mul_pipe: signed multiplier with STAGES register stages,
// carrying valid, sideband and bias alongside the product.
module dsp_mul_pipe
    import dsp_pkg::*;
#(
    parameter int A_WIDTH = DSP_A_W,
    parameter int B_WIDTH = DSP_B_W,
    parameter int C_WIDTH = DSP_ACC_W,
    parameter int STAGES  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic signed [A_WIDTH-1:0]      in_a,
    input  logic signed [B_WIDTH-1:0]      in_b,
    input  sb_t                            in_sb,
    input  logic signed [C_WIDTH-1:0]      in_c,
    output logic                           out_valid,
    output logic signed [A_WIDTH+B_WIDTH-1:0] out_p,
    output sb_t                            out_sb,
    output logic signed [C_WIDTH-1:0]      out_c
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic                      v_q  [STAGES];
    logic                      v_d  [STAGES];
    logic signed [P_WIDTH-1:0] p_q  [STAGES];
    logic signed [P_WIDTH-1:0] p_d  [STAGES];
    sb_t                       sb_q [STAGES];
    sb_t                       sb_d [STAGES];
    logic signed [C_WIDTH-1:0] c_q  [STAGES];
    logic signed [C_WIDTH-1:0] c_d  [STAGES];

    // Shift the pipe forward when not stalled; otherwise hold.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            v_d[i]  = v_q[i];
            p_d[i]  = p_q[i];
            sb_d[i] = sb_q[i];
            c_d[i]  = c_q[i];
        end
        if (en) begin
            v_d[0]  = in_valid;
            p_d[0]  = P_WIDTH'(in_a) * P_WIDTH'(in_b);
            sb_d[0] = in_sb;
            c_d[0]  = in_c;
            for (int i = 1; i < STAGES; i++) begin
                v_d[i]  = v_q[i-1];
                p_d[i]  = p_q[i-1];
                sb_d[i] = sb_q[i-1];
                c_d[i]  = c_q[i-1];
            end
        end
    end

    // Stage registers; reset drops every in-flight beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i]  <= 1'b0;
                p_q[i]  <= '0;
                sb_q[i] <= '0;
                c_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i]  <= v_d[i];
                p_q[i]  <= p_d[i];
                sb_q[i] <= sb_d[i];
                c_q[i]  <= c_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_p     = p_q[STAGES-1];
    assign out_sb    = sb_q[STAGES-1];
    assign out_c     = c_q[STAGES-1];

endmodule

// File: rtl/dsp_mac_stream.sv
// dsp_mac_stream: streaming signed MAC lane, C + sum(+-A*B) per packet.
// Define DSP_MAC_SAT_EN for saturating accumulate with sticky overflow.
module dsp_mac_stream
    import dsp_pkg::*;
#(
    parameter int A_WIDTH    = DSP_A_W,
    parameter int B_WIDTH    = DSP_B_W,
    parameter int ACC_WIDTH  = DSP_ACC_W,
    parameter int MUL_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   in_a,
    input  logic signed [B_WIDTH-1:0]   in_b,
    input  logic signed [ACC_WIDTH-1:0] in_c,
    input  logic                        in_sub,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_WIDTH-1:0] out_p,
    output logic                        out_overflow
);
    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    logic                        stall;
    logic                        accept;
    logic                        first_q, first_d;
    sb_t                         in_sb;
    logic                        mul_valid;
    logic signed [P_WIDTH-1:0]   mul_p;
    sb_t                         mul_sb;
    logic signed [ACC_WIDTH-1:0] mul_c;
    logic signed [ACC_WIDTH-1:0] prod_ext, term, base, raw, sum;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic signed [ACC_WIDTH-1:0] out_p_q, out_p_d;
    logic                        out_valid_q, out_valid_d;
`ifdef DSP_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
        {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
        {1'b1, {(ACC_WIDTH-1){1'b0}}};
    logic ovf_q, ovf_d, out_ovf_q, out_ovf_d;
    logic ovf_now, ovf_cur;
`endif

    // Handshake and first-beat tracking.
    always_comb begin
        stall    = !enable || (out_valid_q && !out_ready);
        in_ready = !rst && !stall;
        accept   = in_valid && in_ready;
        in_sb    = '{first: first_q, last: in_last, sub: in_sub};
        first_d  = first_q;
        if (accept) first_d = in_last;
    end

    dsp_mul_pipe #(
        .A_WIDTH (A_WIDTH),
        .B_WIDTH (B_WIDTH),
        .C_WIDTH (ACC_WIDTH),
        .STAGES  (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .en        (!stall),
        .in_valid  (accept),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sb     (in_sb),
        .in_c      (in_c),
        .out_valid (mul_valid),
        .out_p     (mul_p),
        .out_sb    (mul_sb),
        .out_c     (mul_c)
    );

    // Signed add of the (optionally negated) product, with clamping.
    always_comb begin
        prod_ext = ACC_WIDTH'(mul_p);
        term     = mul_sb.sub ? -prod_ext : prod_ext;
        base     = mul_sb.first ? mul_c : acc_q;
        raw      = base + term;
        sum      = raw;
`ifdef DSP_MAC_SAT_EN
        ovf_now  = 1'b0;
        if (sat_hi(base[ACC_WIDTH-1], term[ACC_WIDTH-1],
                   raw[ACC_WIDTH-1])) begin
            sum     = ACC_MAX;
            ovf_now = 1'b1;
        end else if (sat_lo(base[ACC_WIDTH-1], term[ACC_WIDTH-1],
                            raw[ACC_WIDTH-1])) begin
            sum     = ACC_MIN;
            ovf_now = 1'b1;
        end
        ovf_cur  = (mul_sb.first ? 1'b0 : ovf_q) | ovf_now;
`endif
    end

    // Accumulate, and on the last beat load the result register.
    always_comb begin
        acc_d       = acc_q;
        out_p_d     = out_p_q;
        out_valid_d = out_valid_q;
`ifdef DSP_MAC_SAT_EN
        ovf_d       = ovf_q;
        out_ovf_d   = out_ovf_q;
`endif
        if (!stall) begin
            out_valid_d = 1'b0;
            if (mul_valid) begin
                if (mul_sb.last) begin
                    out_p_d     = sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
`ifdef DSP_MAC_SAT_EN
                    out_ovf_d   = ovf_cur;
                    ovf_d       = 1'b0;
`endif
                end else begin
                    acc_d = sum;
`ifdef DSP_MAC_SAT_EN
                    ovf_d = ovf_cur;
`endif
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q     <= 1'b1;
            acc_q       <= '0;
            out_p_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef DSP_MAC_SAT_EN
            ovf_q       <= 1'b0;
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            first_q     <= first_d;
            acc_q       <= acc_d;
            out_p_q     <= out_p_d;
            out_valid_q <= out_valid_d;
`ifdef DSP_MAC_SAT_EN
            ovf_q       <= ovf_d;
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
`ifdef DSP_MAC_SAT_EN
    assign out_overflow = out_ovf_q;
`else
    assign out_overflow = 1'b0;
`endif

endmodule
